// File: rtl/xmul_pipe_mult_if.sv
// rtl/xmul_pipe_mult_if.sv - operand/product bundle for the pipelined signed multiplier
interface xmul_pipe_mult_if #(
   parameter int DATA_W = 32
);
   logic [DATA_W-1:0]   op_a;
   logic [DATA_W-1:0]   op_b;
   logic [2*DATA_W-1:0] product;

   modport master (output op_a, output op_b, input product);
   modport slave  (input op_a, input op_b, output product);
endinterface

// File: rtl/xmul_pipe_mult.sv
// rtl/xmul_pipe_mult.sv - three-stage signed multiplier, one result per clock
// Stage 1 registers operands, stage 2 forms half-width partial products, stage 3 sums them.
module xmul_pipe_mult #(
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   xmul_pipe_mult_if.slave     bus
);
   localparam int H = DATA_W / 2;

   logic [DATA_W-1:0]     a_r, b_r;
   logic signed [DATA_W-1:0] pp_hh;
   logic signed [DATA_W:0]   pp_hl, pp_lh;
   logic [DATA_W-1:0]     pp_ll;
   logic [2*DATA_W-1:0]   prod_r;

   // Operand halves widened so each multiply is computed at the width of its exact result.
   logic signed [DATA_W-1:0] a_hs, b_hs;
   logic signed [DATA_W:0]   a_hw, b_hw, a_lw, b_lw;
   logic [DATA_W-1:0]        a_lu, b_lu;

   assign a_hs = {{H{a_r[DATA_W-1]}}, a_r[DATA_W-1:H]};
   assign b_hs = {{H{b_r[DATA_W-1]}}, b_r[DATA_W-1:H]};
   assign a_hw = {{(H+1){a_r[DATA_W-1]}}, a_r[DATA_W-1:H]};
   assign b_hw = {{(H+1){b_r[DATA_W-1]}}, b_r[DATA_W-1:H]};
   assign a_lw = {{(H+1){1'b0}}, a_r[H-1:0]};
   assign b_lw = {{(H+1){1'b0}}, b_r[H-1:0]};
   assign a_lu = {{H{1'b0}}, a_r[H-1:0]};
   assign b_lu = {{H{1'b0}}, b_r[H-1:0]};

   logic signed [DATA_W-1:0] hh_n;
   logic signed [DATA_W:0]   hl_n, lh_n;
   logic [DATA_W-1:0]        ll_n;

   assign hh_n = a_hs * b_hs;
   assign hl_n = a_hw * b_lw;
   assign lh_n = a_lw * b_hw;
   assign ll_n = a_lu * b_lu;

   logic [2*DATA_W-1:0] hh_x, hl_x, lh_x, ll_x, sum_n;

   assign hh_x  = {{DATA_W{pp_hh[DATA_W-1]}}, pp_hh} << DATA_W;
   assign hl_x  = {{(DATA_W-1){pp_hl[DATA_W]}}, pp_hl} << H;
   assign lh_x  = {{(DATA_W-1){pp_lh[DATA_W]}}, pp_lh} << H;
   assign ll_x  = {{DATA_W{1'b0}}, pp_ll};
   assign sum_n = hh_x + hl_x + lh_x + ll_x;

   always_ff @(posedge clk) begin
      if (!rst) begin
         a_r    <= '0;
         b_r    <= '0;
         pp_hh  <= '0;
         pp_hl  <= '0;
         pp_lh  <= '0;
         pp_ll  <= '0;
         prod_r <= '0;
      end else begin
         a_r    <= bus.op_a;
         b_r    <= bus.op_b;
         pp_hh  <= hh_n;
         pp_hl  <= hl_n;
         pp_lh  <= lh_n;
         pp_ll  <= ll_n;
         prod_r <= sum_n;
      end
   end

   assign bus.product = prod_r;
endmodule

// File: tb/tb_xmul_pipe_mult.sv
// tb/tb_xmul_pipe_mult.sv - directed and random checks of the pipelined signed multiplier
module tb_xmul_pipe_mult;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   failures = 0;

   logic [63:0] expq[$];
   string       tagq[$];

   xmul_pipe_mult_if #(.DATA_W(32)) bus ();

   xmul_pipe_mult #(.DATA_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] exp);
      checks++;
      assert (bus.product === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, bus.product, exp);
      end
   endtask

   // Result of the pair sampled at one edge is visible after the second edge following it.
   task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp);
      bus.op_a = a;
      bus.op_b = b;
      expq.push_back(exp);
      tagq.push_back(tag);
      @(posedge clk);
      #1;
      if (expq.size() >= 3) chk(tagq.pop_front(), expq.pop_front());
   endtask

   task automatic reset_edges(input int n);
      rst = 1'b0;
      for (int i = 0; i < n; i++) begin
         bus.op_a = $urandom;
         bus.op_b = $urandom;
         @(posedge clk);
         #1;
         chk("reset", 64'h0);
      end
      rst = 1'b1;
      expq.delete();
      tagq.delete();
      for (int i = 0; i < 2; i++) begin
         expq.push_back(64'h0);
         tagq.push_back("refill_zero");
      end
   endtask

   task automatic flush();
      for (int i = 0; i < 2; i++) step("flush", 32'h0, 32'h0, 64'h0);
   endtask

   initial begin
      logic [31:0] ra, rb;
      logic signed [63:0] sa, sb, sp;

      bus.op_a = 32'h1234_5678;
      bus.op_b = 32'h9ABC_DEF0;
      #2;
      reset_edges(2);

      step("rst_release_10x1", 32'd10, 32'd1, 64'd10);
      flush();

      step("zero_x_one", 32'd0,  32'd1,  64'd0);
      step("one_x_zero", 32'd1,  32'd0,  64'd0);
      step("ten_x_one",  32'd10, 32'd1,  64'd10);
      step("one_x_ten",  32'd1,  32'd10, 64'd10);

      step("neg1_x_neg1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
      step("neg1_x_one",  32'hFFFF_FFFF, 32'h0000_0001, 64'hFFFF_FFFF_FFFF_FFFF);
      step("min_x_min",   32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
      step("min_x_max",   32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000);
      step("max_x_max",   32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001);
      step("half_carry",  32'h0000_FFFF, 32'h0000_FFFF, 64'h0000_0000_FFFE_0001);
      step("half_shift",  32'hFFFF_0000, 32'h0001_0000, 64'hFFFF_FFFF_0000_0000);
      flush();

      for (int i = 0; i < 200; i++) begin
         ra = $random;
         rb = $random;
         sa = $signed(ra);
         sb = $signed(rb);
         sp = sa * sb;
         step("random", ra, rb, sp);
      end
      flush();

      // Three results in flight when reset hits; none of them may surface.
      bus.op_a = 32'd3;
      bus.op_b = 32'd5;
      @(posedge clk);
      #1;
      bus.op_a = 32'd7;
      bus.op_b = 32'd11;
      @(posedge clk);
      #1;
      bus.op_a = 32'hFFFF_FFFE;
      bus.op_b = 32'd13;
      @(posedge clk);
      #1;
      expq.delete();
      tagq.delete();
      reset_edges(1);
      step("resume_a", 32'd6,  32'hFFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFD6);
      step("resume_b", 32'd9,  32'd9,         64'd81);
      flush();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
